// File: rtl/seg_mux.sv
// Four-digit multiplexed 7-segment driver with frame-coherent shadow capture and anti-ghosting blanking.
// Optional PWM dimming from `brightness` is compiled in when SEG_MUX_DIMMING_EN is defined.
module seg_mux #(
    parameter int REFRESH_COUNT_MAX = 100000,
    parameter int BLANK_CYCLES      = 1000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] dig_0,
    input  logic [7:0] dig_1,
    input  logic [7:0] dig_2,
    input  logic [7:0] dig_3,
    input  logic [3:0] brightness,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       frame_tick
);

    localparam int CW = $clog2(REFRESH_COUNT_MAX);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_COUNT_MAX - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    shadow_q [4];
    logic [7:0]    shadow_d [4];
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick_q, tick_d;
    phase_e        phase;
    logic          lit;

`ifndef SEG_MUX_DIMMING_EN
    logic unused_brightness;
    assign unused_brightness = ^brightness;
`endif

    // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned (no latches).
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tick_d   = 1'b0;
        an_d     = 4'b1111;
        seg_d    = 8'hFF;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            // Whole-frame capture at the 3->0 wrap keeps all four digits from the same upstream sample.
            if (idx_q == 2'd3) begin
                shadow_d = '{dig_0, dig_1, dig_2, dig_3};
                tick_d   = 1'b1;
            end
        end

        phase = (cnt_q < BLANK_END) ? PH_BLANK : PH_DRIVE;
        lit   = (phase == PH_DRIVE);
`ifdef SEG_MUX_DIMMING_EN
        lit   = lit && (cnt_q[3:0] < brightness);
`endif
        if (lit) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = shadow_q[idx_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            // NOTE: the shadows are four discrete registers, not a RAM, so resetting them to blank is cheap and required.
            shadow_q <= '{default: 8'hFF};
            an_q     <= 4'b1111;
            seg_q    <= 8'hFF;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            tick_q   <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_mux.sv
// Self-checking bench for seg_mux: a frame-level model (edge count -> slot/phase/captured frame) checked every cycle,
// plus literal expectations for scan order, frame capture, frame_tick, reset behaviour and dimming.
module tb_seg_mux;

`ifdef SEG_MUX_DIMMING_EN
    localparam int R = 64;
`else
    localparam int R = 32;
`endif
    localparam int B     = 4;
    localparam int FRAME = 4 * R;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] dig_0, dig_1, dig_2, dig_3;
    logic [3:0] brightness;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_tick;

    seg_mux #(.REFRESH_COUNT_MAX(R), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .dig_0      (dig_0),
        .dig_1      (dig_1),
        .dig_2      (dig_2),
        .dig_3      (dig_3),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: after rising edge number e since reset release, outputs show slot (e/R)%4 at count e%R,
    // with the digits that were on the inputs at the last edge closing the previous frame.
    int         edges = 0;
    logic [7:0] m_shadow [4] = '{default: 8'hFF};
    logic [3:0] exp_an   = 4'hF;
    logic [7:0] exp_seg  = 8'hFF;
    logic       exp_tick = 1'b0;
    logic [3:0] an_of_slot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int         m_cnt, m_slot;
    bit         m_lit;

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            edges    = 0;
            m_shadow = '{default: 8'hFF};
            exp_an   = 4'hF;
            exp_seg  = 8'hFF;
            exp_tick = 1'b0;
        end else begin
            m_cnt  = edges % R;
            m_slot = (edges / R) % 4;
            m_lit  = (m_cnt >= B);
`ifdef SEG_MUX_DIMMING_EN
            m_lit  = m_lit && ((m_cnt % 16) < int'(brightness));
`endif
            exp_an   = m_lit ? an_of_slot[m_slot] : 4'hF;
            exp_seg  = m_lit ? m_shadow[m_slot] : 8'hFF;
            exp_tick = ((edges % FRAME) == FRAME - 1);
            if ((edges % FRAME) == FRAME - 1)
                m_shadow = '{dig_0, dig_1, dig_2, dig_3};
            edges++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("an_cycle", {28'd0, an}, {28'd0, exp_an});
            check("seg_cycle", {24'd0, seg}, {24'd0, exp_seg});
            check("frame_tick_cycle", {31'd0, frame_tick}, {31'd0, exp_tick});
        end
    end

    task automatic at_edge(input int e);
        int guard = 0;
        while (edges < e + 1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_edge", edges, e + 1);
    endtask

    task automatic expect_at(input string name, input int e, input logic [3:0] a, input logic [7:0] s);
        at_edge(e);
        check({name, "_an"}, {28'd0, an}, {28'd0, a});
        check({name, "_seg"}, {24'd0, seg}, {24'd0, s});
    endtask

    task automatic set_digits();
        dig_0 = 8'hC0;
        dig_1 = 8'hF9;
        dig_2 = 8'hA4;
        dig_3 = 8'hB0;
    endtask

    int f;

    initial begin
        resetn     = 1'b1;
        brightness = 4'd15;
        dig_0 = 8'($urandom); dig_1 = 8'($urandom); dig_2 = 8'($urandom); dig_3 = 8'($urandom);
        #1 resetn = 1'b0;
        chk_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            dig_0 = 8'($urandom); dig_1 = 8'($urandom); dig_2 = 8'($urandom); dig_3 = 8'($urandom);
        end
        check("reset_an", {28'd0, an}, 32'hF);
        check("reset_seg", {24'd0, seg}, 32'hFF);
        check("reset_tick", {31'd0, frame_tick}, 32'd0);
        set_digits();
        @(negedge clk);
        resetn = 1'b1;

        // Scan order: frame 0 is blank data, frame 1 shows the captured digits.
        expect_at("f0_blank", B - 1, 4'hF, 8'hFF);
        expect_at("f0_s0", B, 4'hE, 8'hFF);
        expect_at("f0_s1", R + B, 4'hD, 8'hFF);
        at_edge(FRAME - 1);
        check("tick_first", {31'd0, frame_tick}, 32'd1);
        at_edge(FRAME);
        check("tick_one_cycle", {31'd0, frame_tick}, 32'd0);
        check("f1_s0_blank_an", {28'd0, an}, 32'hF);
        expect_at("f1_s0", FRAME + B, 4'hE, 8'hC0);
        expect_at("f1_s1", FRAME + R + B, 4'hD, 8'hF9);
        expect_at("f1_s2", FRAME + 2 * R + B, 4'hB, 8'hA4);
        expect_at("f1_s3", FRAME + 3 * R + B, 4'h7, 8'hB0);

        // Change dig_1 mid-frame: only visible from the next frame onward.
        at_edge(2 * FRAME + 2 * R + 5);
        dig_1 = 8'h99;
        expect_at("f2_s3_steady", 2 * FRAME + 3 * R + B, 4'h7, 8'hB0);
        expect_at("f3_s0", 3 * FRAME + B, 4'hE, 8'hC0);
        expect_at("f3_s1_new", 3 * FRAME + R + B, 4'hD, 8'h99);

        // Randomised inputs and brightness, checked every cycle by the model.
        repeat (8 * FRAME) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: dig_0 = 8'($urandom);
                    1: dig_1 = 8'($urandom);
                    2: dig_2 = 8'($urandom);
                    default: dig_3 = 8'($urandom);
                endcase
            end
            brightness = 4'($urandom);
        end

        // Dimming at brightness 4, then 0.
        @(negedge clk);
        set_digits();
        brightness = 4'd4;
        f = edges / FRAME + 2;
`ifdef SEG_MUX_DIMMING_EN
        expect_at("dim4_cnt4", f * FRAME + B, 4'hF, 8'hFF);
        expect_at("dim4_cnt18", f * FRAME + 18, 4'hE, 8'hC0);
        expect_at("dim4_cnt20", f * FRAME + 20, 4'hF, 8'hFF);
`else
        expect_at("dim4_cnt4", f * FRAME + B, 4'hE, 8'hC0);
        expect_at("dim4_cnt18", f * FRAME + 18, 4'hE, 8'hC0);
        expect_at("dim4_cnt20", f * FRAME + 20, 4'hE, 8'hC0);
`endif
        brightness = 4'd0;
        f = edges / FRAME + 1;
`ifdef SEG_MUX_DIMMING_EN
        expect_at("dim0_s1", f * FRAME + R + 18, 4'hF, 8'hFF);
`else
        expect_at("dim0_s1", f * FRAME + R + 18, 4'hD, 8'hF9);
`endif

        // Asynchronous reset in the middle of slot 2.
        f = edges / FRAME + 1;
        at_edge(f * FRAME + 2 * R + 10);
        @(posedge clk);
        #2 resetn = 1'b0;
        dig_0 = 8'($urandom); dig_1 = 8'($urandom); dig_2 = 8'($urandom); dig_3 = 8'($urandom);
        #1;
        check("midrst_an", {28'd0, an}, 32'hF);
        check("midrst_seg", {24'd0, seg}, 32'hFF);
        check("midrst_tick", {31'd0, frame_tick}, 32'd0);
        repeat (3) @(negedge clk);
        set_digits();
        brightness = 4'd15;
        resetn = 1'b1;
        expect_at("postrst_blank", B - 1, 4'hF, 8'hFF);
        expect_at("postrst_s0", B, 4'hE, 8'hFF);
        expect_at("postrst_s1", R + B, 4'hD, 8'hFF);
        at_edge(FRAME - 1);
        check("postrst_tick", {31'd0, frame_tick}, 32'd1);
        expect_at("postrst_f1_s0", FRAME + B, 4'hE, 8'hC0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_mux.md
SEG_MUX -- requirements
Module: seg_mux

Interface
REQ-001 Parameter REFRESH_COUNT_MAX, default 100000; clock cycles per digit slot (1 ms at 100 MHz); SHALL be greater than BLANK_CYCLES + 16.
REQ-002 Parameter BLANK_CYCLES, default 1000; anti-ghosting dead time, in cycles, at the start of each slot; SHALL be at least 1.
REQ-003 clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 dig_0..dig_3  input  8 each  segment patterns from the upstream heartbeat; active-low, bit 7 = DP; dig_0 is the rightmost digit.
REQ-006 brightness  input  4  dimming level; used only when SEG_MUX_DIMMING_EN is defined.
REQ-007 an  output  4  digit anodes, active-low, registered.
REQ-008 seg  output  8  segment cathodes, active-low, registered.
REQ-009 frame_tick  output  1  one-cycle pulse per completed four-digit scan, registered.

Function
REQ-010 Refresh counter cnt SHALL count 0..REFRESH_COUNT_MAX-1, then wrap to 0; its width SHALL be $clog2(REFRESH_COUNT_MAX).
REQ-011 Digit index idx (2 bits) SHALL advance 0->1->2->3->0 on each cnt wrap.
REQ-012 Four 8-bit shadow registers SHALL capture dig_0..dig_3 together, only on the cycle where cnt wraps and idx==3.
REQ-013 Input changes between captures SHALL NOT affect displayed data; no tearing within a frame.
REQ-014 The per-slot phase SHALL be BLANK while cnt < BLANK_CYCLES, and DRIVE otherwise.
REQ-015 In BLANK: an = 4'b1111 and seg = 8'hFF.
REQ-016 In DRIVE: an SHALL have only bit idx low, and seg = shadow[idx].
REQ-017 an and seg SHALL lag the internal cnt/idx state by exactly one cycle.
REQ-018 frame_tick SHALL be high for exactly one cycle, the cycle after the idx 3->0 wrap; its period is 4*REFRESH_COUNT_MAX cycles.
REQ-019 The first frame after reset SHALL scan the anodes with seg = 8'hFF (shadow reset value).
REQ-020 Captured data SHALL first appear in slot 0 of the following frame.

Reset
REQ-021 While resetn is low, asynchronously: cnt=0, idx=0, shadows=8'hFF, an=4'b1111, seg=8'hFF, frame_tick=0.
REQ-022 After resetn deasserts, scanning SHALL start at slot 0, BLANK phase, with cnt=0 on the first rising edge.
REQ-023 Reset asserted mid-slot or mid-frame SHALL abort the scan immediately; no partial capture of shadow registers.

Configuration
REQ-024 Macro SEG_MUX_DIMMING_EN defined: in DRIVE, an SHALL be enabled only when cnt[3:0] < brightness; otherwise an = 4'b1111 and seg = 8'hFF.
REQ-025 With the macro defined: brightness=0 blanks the display; brightness=15 gives 15/16 duty.
REQ-026 With the macro defined: brightness SHALL be sampled every cycle, with no sync stage.
REQ-027 Macro undefined: brightness SHALL be ignored and DRIVE SHALL be full duty; all other behaviour is identical.

Verification
All scenarios use REFRESH_COUNT_MAX=32 and BLANK_CYCLES=4 unless stated.
REQ-028 Reset: hold resetn=0 for 5 cycles with arbitrary dig_* -> an=4'hF, seg=8'hFF, frame_tick=0 throughout, including mid-cycle assertion.
REQ-029 Scan order: dig_0=8'hC0, dig_1=8'hF9, dig_2=8'hA4, dig_3=8'hB0 held steady.
  -> Frame 2 shows an 1110/1101/1011/0111 with seg C0/F9/A4/B0.
  -> Each slot has 4 cycles of blank, then 28 cycles driven.
  -> Frame 1 shows seg=8'hFF.
REQ-030 Frame-coherent capture: change dig_1 from 8'hF9 to 8'h99 during slot 2 -> slot 1 still shows F9 this frame, and shows 99 from the next frame.
REQ-031 frame_tick: run 4 frames -> exactly 4 single-cycle pulses, spaced 128 cycles apart, each one cycle after the idx 3->0 wrap.
REQ-032 Reset mid-scan: assert resetn=0 asynchronously in slot 2, then release.
  -> Outputs blank within the same cycle.
  -> The next driven slot is slot 0 with seg=8'hFF.
REQ-033 Dimming (macro defined), REFRESH_COUNT_MAX=64, BLANK_CYCLES=4, brightness=4:
  -> In DRIVE, an is active only when cnt[3:0] is 0..3.
  -> brightness=0 gives an=4'hF always.
  -> With the macro undefined, the same bench shows full duty.
